// File: rtl/lstm_seq_ctrl_pkg.sv
// Shared definitions for the LSTM timestep sequencer: FSM state encodings,
// gate indices and timing helpers.
package lstm_seq_ctrl_pkg;

    typedef logic [3:0] state_t;

    localparam state_t S_IDLE     = 4'd0;
    localparam state_t S_CLR      = 4'd1;
    localparam state_t S_X_MAC    = 4'd2;
    localparam state_t S_H_MAC    = 4'd3;
    localparam state_t S_BIAS     = 4'd4;
    localparam state_t S_ACT_WAIT = 4'd5;
    localparam state_t S_GWR      = 4'd6;
    localparam state_t S_NET_C1   = 4'd7;
    localparam state_t S_NET_C2   = 4'd8;
    localparam state_t S_NET_H    = 4'd9;
    localparam state_t S_NWR      = 4'd10;
    localparam state_t S_STEP_END = 4'd11;
    localparam state_t S_DONE     = 4'd12;

    localparam logic [1:0] GATE_I = 2'd0;
    localparam logic [1:0] GATE_F = 2'd1;
    localparam logic [1:0] GATE_G = 2'd2;
    localparam logic [1:0] GATE_O = 2'd3;

    // Index width that never collapses to zero bits for tiny dimensions.
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int gate_cyc(input int n_in, input int n_hid, input int act_lat);
        return n_in + n_hid + 3 + act_lat;
    endfunction

    function automatic int step_cyc(input int n_in, input int n_hid, input int act_lat);
        return n_hid * (4 * gate_cyc(n_in, n_hid, act_lat) + 4) + 1;
    endfunction

endpackage

// File: rtl/lstm_seq_ctrl_if.sv
// Control bundle between the top-level launcher (master) and the sequencer
// (slave), carrying the gate/network/memory strobes and indices.
interface lstm_seq_ctrl_if #(
    parameter int N_IN  = 16,
    parameter int N_HID = 16,
    parameter int SW    = 8
);
    import lstm_seq_ctrl_pkg::*;

    localparam int EW = idx_w((N_IN > N_HID) ? N_IN : N_HID);
    localparam int UW = idx_w(N_HID);

    logic          chip_en;
    logic          start;
    logic [SW-1:0] num_steps;
    logic          busy;
    logic          done;
    logic          mux_mult_sel;
    logic          mux_acc_sel;
    logic          accum_rst_gate;
    logic [1:0]    gate_sel;
    logic [EW-1:0] elem_idx;
    logic [UW-1:0] unit_idx;
    logic [SW-1:0] step_idx;
    logic          gate_wr;
    logic          accum_rst_net;
    logic          mux_c_gate_sel;
    logic          mux_c_tanh_sel;
    logic          net_wr;
    logic          h_swap;

    modport master (
        output chip_en, start, num_steps,
        input  busy, done, mux_mult_sel, mux_acc_sel, accum_rst_gate, gate_sel,
               elem_idx, unit_idx, step_idx, gate_wr, accum_rst_net,
               mux_c_gate_sel, mux_c_tanh_sel, net_wr, h_swap
    );

    modport slave (
        input  chip_en, start, num_steps,
        output busy, done, mux_mult_sel, mux_acc_sel, accum_rst_gate, gate_sel,
               elem_idx, unit_idx, step_idx, gate_wr, accum_rst_net,
               mux_c_gate_sel, mux_c_tanh_sel, net_wr, h_swap
    );

endinterface

// File: rtl/lstm_seq_ctrl_tc_counter.sv
// Wrapping up-counter with clear, load, enable and a programmable terminal
// count; tc flags the terminal value and the next enabled tick returns to 0.
module lstm_tc_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    input  logic [W-1:0] tc_val,
    output logic [W-1:0] q,
    output logic         tc
);

    assign tc = (q == tc_val);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (load) begin
            q <= load_val;
        end else if (en) begin
            q <= tc ? '0 : q + W'(1);
        end
    end

endmodule

// File: rtl/lstm_seq_ctrl.sv
// LSTM multi-timestep sequencer: walks gates i/f/g/o per hidden unit through
// the shared MAC, then the c/h update, for num_steps timesteps.
module lstm_seq_ctrl
    import lstm_seq_ctrl_pkg::*;
#(
    parameter int N_IN    = 16,
    parameter int N_HID   = 16,
    parameter int ACT_LAT = 2,
    parameter int SW      = 8
) (
    input logic           clk,
    input logic           rst,
    lstm_seq_ctrl_if.slave bus
);

    localparam int EW = idx_w((N_IN > N_HID) ? N_IN : N_HID);
    localparam int UW = idx_w(N_HID);
    localparam int AW = idx_w(ACT_LAT);

    state_t        state, state_nxt;
    logic [SW-1:0] num_steps_q;
    logic          accept;

    logic [EW-1:0] elem_q, elem_tc_val;
    logic [AW-1:0] act_q;
    logic [1:0]    gate_q;
    logic [UW-1:0] unit_q;
    logic [SW-1:0] step_q;
    logic          elem_tc, act_tc, gate_tc, unit_tc, step_tc;

    assign accept      = bus.chip_en && (state == S_IDLE) && bus.start;
    assign elem_tc_val = (state == S_X_MAC) ? EW'(N_IN - 1) : EW'(N_HID - 1);

    // Counters wrap to zero on their terminal tick, so indices are already
    // back at 0 when the FSM leaves the phase that used them.
    lstm_tc_counter #(.W(EW)) u_elem (
        .clk(clk), .rst(rst), .clr(accept), .load(1'b0),
        .en(bus.chip_en && (state == S_X_MAC || state == S_H_MAC)),
        .load_val('0), .tc_val(elem_tc_val), .q(elem_q), .tc(elem_tc)
    );

    lstm_tc_counter #(.W(AW)) u_act (
        .clk(clk), .rst(rst), .clr(accept), .load(1'b0),
        .en(bus.chip_en && (state == S_ACT_WAIT)),
        .load_val('0), .tc_val(AW'(ACT_LAT - 1)), .q(act_q), .tc(act_tc)
    );

    lstm_tc_counter #(.W(2)) u_gate (
        .clk(clk), .rst(rst), .clr(accept), .load(1'b0),
        .en(bus.chip_en && (state == S_GWR)),
        .load_val('0), .tc_val(GATE_O), .q(gate_q), .tc(gate_tc)
    );

    lstm_tc_counter #(.W(UW)) u_unit (
        .clk(clk), .rst(rst), .clr(accept), .load(1'b0),
        .en(bus.chip_en && (state == S_NWR)),
        .load_val('0), .tc_val(UW'(N_HID - 1)), .q(unit_q), .tc(unit_tc)
    );

    lstm_tc_counter #(.W(SW)) u_step (
        .clk(clk), .rst(rst), .clr(accept), .load(1'b0),
        .en(bus.chip_en && (state == S_STEP_END) && !step_tc),
        .load_val('0), .tc_val(num_steps_q - SW'(1)), .q(step_q), .tc(step_tc)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:     if (bus.start) state_nxt = (bus.num_steps == '0) ? S_DONE : S_CLR;
            S_CLR:      state_nxt = S_X_MAC;
            S_X_MAC:    if (elem_tc) state_nxt = S_H_MAC;
            S_H_MAC:    if (elem_tc) state_nxt = S_BIAS;
            S_BIAS:     state_nxt = S_ACT_WAIT;
            S_ACT_WAIT: if (act_tc) state_nxt = S_GWR;
            S_GWR:      state_nxt = gate_tc ? S_NET_C1 : S_CLR;
            S_NET_C1:   state_nxt = S_NET_C2;
            S_NET_C2:   state_nxt = S_NET_H;
            S_NET_H:    state_nxt = S_NWR;
            S_NWR:      state_nxt = unit_tc ? S_STEP_END : S_CLR;
            S_STEP_END: state_nxt = step_tc ? S_DONE : S_CLR;
            S_DONE:     state_nxt = S_IDLE;
            default:    state_nxt = S_IDLE;
        endcase
    end

    // Strobes are decoded from the next state so they line up with the state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state              <= S_IDLE;
            num_steps_q        <= '0;
            bus.busy           <= 1'b0;
            bus.done           <= 1'b0;
            bus.mux_mult_sel   <= 1'b0;
            bus.mux_acc_sel    <= 1'b0;
            bus.accum_rst_gate <= 1'b0;
            bus.gate_wr        <= 1'b0;
            bus.accum_rst_net  <= 1'b0;
            bus.mux_c_gate_sel <= 1'b0;
            bus.mux_c_tanh_sel <= 1'b0;
            bus.net_wr         <= 1'b0;
            bus.h_swap         <= 1'b0;
        end else if (bus.chip_en) begin
            state <= state_nxt;
            if (accept) num_steps_q <= bus.num_steps;
            bus.busy           <= (state_nxt != S_IDLE);
            bus.done           <= (state_nxt == S_DONE);
            bus.mux_mult_sel   <= (state_nxt == S_H_MAC);
            bus.mux_acc_sel    <= (state_nxt == S_BIAS);
            bus.accum_rst_gate <= (state_nxt == S_CLR);
            bus.gate_wr        <= (state_nxt == S_GWR);
            bus.accum_rst_net  <= (state_nxt == S_NET_C1);
            bus.mux_c_gate_sel <= (state_nxt == S_NET_C2);
            bus.mux_c_tanh_sel <= (state_nxt == S_NET_H);
            bus.net_wr         <= (state_nxt == S_NWR);
            bus.h_swap         <= (state_nxt == S_STEP_END);
        end
    end

    assign bus.elem_idx = elem_q;
    assign bus.gate_sel = gate_q;
    assign bus.unit_idx = unit_q;
    assign bus.step_idx = step_q;

endmodule

// File: tb/tb_lstm_seq_ctrl.sv
// Directed bench for lstm_seq_ctrl: expected strobe events are queued at each
// launch and matched (kind, edge, indices) as the sequencer emits them.
module tb_lstm_seq_ctrl;

    localparam int N_IN    = 2;
    localparam int N_HID   = 2;
    localparam int ACT_LAT = 1;
    localparam int SW      = 8;
    localparam int GC      = N_IN + N_HID + 3 + ACT_LAT;
    localparam int UC      = 4 * GC + 4;
    localparam int STEP    = N_HID * UC + 1;

    typedef struct {
        int kind;   // 0 gate_wr, 1 net_wr, 2 h_swap, 3 done
        int at;
        int step;
        int unit;
        int gate;
    } ev_t;

    logic clk;
    logic rst;
    int   cyc;
    int   n_assert;
    int   n_fail;
    int   gw_cnt, nw_cnt, hs_cnt;
    ev_t  sb[$];

    lstm_seq_ctrl_if #(.N_IN(N_IN), .N_HID(N_HID), .SW(SW)) bus ();

    lstm_seq_ctrl #(.N_IN(N_IN), .N_HID(N_HID), .ACT_LAT(ACT_LAT), .SW(SW)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        logic [31:0] v;
        v = {9'd0, bus.busy, bus.done, bus.mux_mult_sel, bus.mux_acc_sel, bus.accum_rst_gate,
             bus.gate_sel, bus.elem_idx, bus.unit_idx, bus.step_idx, bus.gate_wr,
             bus.accum_rst_net, bus.mux_c_gate_sel, bus.mux_c_tanh_sel, bus.net_wr, bus.h_swap};
        return v;
    endfunction

    task automatic wait_edge(input int e);
        @(negedge clk);
        while (cyc < e) @(negedge clk);
    endtask

    task automatic push_run(input int s, input int n, input int shift);
        ev_t e;
        for (int k = 0; k < n; k++) begin
            for (int u = 0; u < N_HID; u++) begin
                for (int g = 0; g < 4; g++) begin
                    e = '{0, s + shift + k*STEP + u*UC + g*GC + GC - 1, k, u, g};
                    sb.push_back(e);
                end
                e = '{1, s + shift + k*STEP + u*UC + 4*GC + 3, k, u, 0};
                sb.push_back(e);
            end
            e = '{2, s + shift + k*STEP + N_HID*UC, k, 0, 0};
            sb.push_back(e);
        end
        e = '{3, s + shift + n*STEP, 0, 0, 0};
        sb.push_back(e);
    endtask

    task automatic do_start(input int n, input int shift, output int s);
        @(negedge clk);
        bus.start     = 1'b1;
        bus.num_steps = SW'(n);
        @(posedge clk);
        #1;
        s = cyc;
        bus.start = 1'b0;
        push_run(s, n, shift);
    endtask

    task automatic drain(input int last);
        wait_edge(last + 2);
        chk("sb_empty", sb.size(), 0);
    endtask

    // Strobe monitor / scoreboard consumer
    always @(negedge clk) begin
        int  kind;
        ev_t e;
        if (!rst && (bus.gate_wr || bus.net_wr || bus.h_swap || bus.done)) begin
            kind = bus.gate_wr ? 0 : bus.net_wr ? 1 : bus.h_swap ? 2 : 3;
            chk("strobe_mutex", $countones({bus.gate_wr, bus.net_wr, bus.h_swap, bus.done}), 1);
            if (bus.gate_wr) gw_cnt++;
            if (bus.net_wr)  nw_cnt++;
            if (bus.h_swap)  hs_cnt++;
            if (sb.size() == 0) begin
                chk("unexpected_strobe_kind", kind, 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                chk("ev_kind", kind, e.kind);
                chk("ev_edge", cyc, e.at);
                if (kind == 0) begin
                    chk("gwr_gate", bus.gate_sel, e.gate);
                    chk("gwr_unit", bus.unit_idx, e.unit);
                    chk("gwr_step", bus.step_idx, e.step);
                end else if (kind == 1) begin
                    chk("nwr_unit", bus.unit_idx, e.unit);
                    chk("nwr_step", bus.step_idx, e.step);
                end else if (kind == 2) begin
                    chk("hswap_step", bus.step_idx, e.step);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        n_assert = 0;
        n_fail   = 0;
        gw_cnt   = 0;
        nw_cnt   = 0;
        hs_cnt   = 0;
        rst           = 1'b1;
        bus.chip_en   = 1'b1;
        bus.start     = 1'b0;
        bus.num_steps = '0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", outs(), 0);
        rst = 1'b0;

        // Single step: per-gate datapath pattern, NET phase selects, strobe counts
        do_start(1, 0, s);
        for (int o = 0; o < GC; o++) begin
            wait_edge(s + o);
            chk("accum_rst_gate", bus.accum_rst_gate, (o == 0));
            chk("mux_mult_sel", bus.mux_mult_sel, (o >= 1 + N_IN) && (o < 1 + N_IN + N_HID));
            chk("mux_acc_sel", bus.mux_acc_sel, (o == 1 + N_IN + N_HID));
            chk("elem_idx",
                bus.elem_idx,
                (o >= 1 && o <= N_IN) ? o - 1 :
                (o > N_IN && o <= N_IN + N_HID) ? o - 1 - N_IN : 0);
        end
        wait_edge(s + GC);
        chk("gate_sel_next", bus.gate_sel, 1);
        wait_edge(s + 4*GC);
        chk("net_c1_rst", bus.accum_rst_net, 1);
        chk("net_c1_sel", bus.mux_c_gate_sel, 0);
        wait_edge(s + 4*GC + 1);
        chk("net_c2_sel", bus.mux_c_gate_sel, 1);
        wait_edge(s + 4*GC + 2);
        chk("net_h_sel", bus.mux_c_tanh_sel, 1);
        drain(s + STEP);
        chk("gate_wr_count", gw_cnt, 4 * N_HID);
        chk("net_wr_count", nw_cnt, N_HID);
        chk("h_swap_count", hs_cnt, 1);
        chk("idle_busy", bus.busy, 0);

        // Three steps with a stray start and num_steps change mid-run
        do_start(3, 0, s);
        wait_edge(s + 10);
        chk("busy_mid_run", bus.busy, 1);
        bus.start     = 1'b1;
        bus.num_steps = 8'd7;
        repeat (3) @(negedge clk);
        bus.start     = 1'b0;
        bus.num_steps = 8'd1;
        drain(s + 3*STEP);

        // Zero timesteps
        do_start(0, 0, s);
        wait_edge(s);
        chk("zero_busy", bus.busy, 1);
        wait_edge(s + 1);
        chk("zero_busy_drop", bus.busy, 0);
        drain(s + 1);

        // chip_en low for five edges in the first H_MAC
        do_start(1, 5, s);
        wait_edge(s + 1 + N_IN);
        chk("pre_freeze_mult", bus.mux_mult_sel, 1);
        bus.chip_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wait_edge(s + 2 + N_IN + i);
            chk("freeze_mult", bus.mux_mult_sel, 1);
            chk("freeze_elem", bus.elem_idx, 0);
            chk("freeze_busy", bus.busy, 1);
        end
        bus.chip_en = 1'b1;
        wait_edge(s + 2 + N_IN + 5);
        chk("post_freeze_elem", bus.elem_idx, 1);
        drain(s + 5 + STEP);

        // Reset during NET_C2, then a fresh full run
        do_start(2, 0, s);
        wait_edge(s + 4*GC + 1);
        chk("pre_rst_net_c2", bus.mux_c_gate_sel, 1);
        #2;
        rst = 1'b1;
        sb.delete();
        #1;
        chk("mid_rst_outputs", outs(), 0);
        @(negedge clk);
        rst = 1'b0;
        do_start(1, 0, s);
        drain(s + STEP);
        chk("final_busy", bus.busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
